// File: rtl/pattern_sweeper_pkg.sv
// Shared types and helpers for the pattern sweeper: FSM states and Gray conversion.
package pattern_sweeper_pkg;

  localparam int MAX_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/sweep_dwell_cnt.sv
// Dwell timer: free-runs 0..DWELL-1 while enabled and flags the final cycle of each dwell.
module sweep_dwell_cnt #(
  parameter int DWELL = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic last_o
);

  logic [7:0] count_q;

  assign last_o = (count_q == 8'(DWELL - 1));

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else if (clear_i || last_o) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_q + 8'd1;
    end
  end

endmodule

// File: rtl/pattern_sweeper.sv
// Exhaustive stimulus sweeper: drives every WIDTH-bit pattern for DWELL cycles,
// compares the DUT response against a truth table and reports pass / error statistics.
module pattern_sweeper
  import pattern_sweeper_pkg::*;
#(
  parameter int                  WIDTH  = 4,
  parameter int                  DWELL  = 10,
  parameter logic [2**WIDTH-1:0] EXPECT = '0,
  parameter int                  GRAY   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             resp,
  output logic [WIDTH-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_cnt,
  output logic [WIDTH-1:0] first_fail
);

  localparam int CW = WIDTH + 1;

  state_e           state_q;
  logic [WIDTH-1:0] index_q;
  logic [WIDTH-1:0] pattern_q;
  logic [WIDTH-1:0] first_fail_q;
  logic [CW-1:0]    err_cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic             dwell_clear;
  logic             dwell_last;
  logic             mismatch;
  logic             last_index;
  logic [WIDTH-1:0] index_d;
  logic [WIDTH-1:0] pattern_d;
  logic [CW-1:0]    err_cnt_d;

  // Timer is held at zero outside SWEEP so each sweep starts on a fresh dwell.
  assign dwell_clear = (state_q != SWEEP) || abort;

  sweep_dwell_cnt #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(dwell_clear),
    .last_o (dwell_last)
  );

  assign mismatch   = (resp != EXPECT[pattern_q]);
  assign last_index = (index_q == {WIDTH{1'b1}});
  assign index_d    = index_q + WIDTH'(1);
  assign pattern_d  = (GRAY != 0) ? WIDTH'(bin2gray(MAX_WIDTH'(index_d))) : index_d;
  assign err_cnt_d  = err_cnt_q + CW'(mismatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      index_q      <= '0;
      pattern_q    <= '0;
      first_fail_q <= '0;
      err_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q      <= SWEEP;
            index_q      <= '0;
            pattern_q    <= '0;
            first_fail_q <= '0;
            err_cnt_q    <= '0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        SWEEP: begin
          if (abort) begin
            state_q   <= IDLE;
            index_q   <= '0;
            pattern_q <= '0;
            busy_q    <= 1'b0;
            pass_q    <= 1'b0;
          end else if (dwell_last) begin
            if (mismatch) begin
              err_cnt_q <= err_cnt_d;
              if (err_cnt_q == '0) first_fail_q <= pattern_q;
            end
            if (last_index) begin
              // Verdict folds in the final pattern's comparison made on this same edge.
              state_q   <= DONE;
              index_q   <= '0;
              pattern_q <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              pass_q    <= (err_cnt_q == '0) && !mismatch;
            end else begin
              index_q   <= index_d;
              pattern_q <= pattern_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pattern    = pattern_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_pattern_sweeper.sv
// Scoreboard bench for pattern_sweeper: stimulus queues expected sweep results,
// monitors pop and compare on each done pulse (and per-cycle Gray patterns).
module tb_pattern_sweeper;

  typedef struct {
    logic       pass;
    logic [4:0] err;
    logic [3:0] ff;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, resp;
  logic [1:0] mode;
  logic [3:0] pattern, first_fail;
  logic       busy, done, pass;
  logic [4:0] err_cnt;

  logic       start_g;
  logic [3:0] pattern_g, first_fail_g;
  logic       busy_g, done_g, pass_g;
  logic [4:0] err_cnt_g;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];
  logic [3:0] g_q[$];
  logic [3:0] gray_tab [16];

  always #5 clk = ~clk;

  assign resp = (mode == 2'd0) ? &pattern : (mode == 2'd1) ? 1'b0 : 1'b1;

  pattern_sweeper #(.WIDTH(4), .DWELL(10), .EXPECT(16'h8000), .GRAY(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .resp(resp),
    .pattern(pattern), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_fail(first_fail)
  );

  pattern_sweeper #(.WIDTH(4), .DWELL(10), .EXPECT(16'h0000), .GRAY(1)) dut_g (
    .clk(clk), .rst_n(rst_n), .start(start_g), .abort(1'b0), .resp(1'b0),
    .pattern(pattern_g), .busy(busy_g), .done(done_g), .pass(pass_g),
    .err_cnt(err_cnt_g), .first_fail(first_fail_g)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor for the binary instance: one scoreboard entry per done pulse.
  int   busy_run = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        check("done_one_cycle", {31'd0, prev_done}, 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("pass", {31'd0, pass}, {31'd0, e.pass});
          check("err_cnt", {27'd0, err_cnt}, {27'd0, e.err});
          check("first_fail", {28'd0, first_fail}, {28'd0, e.ff});
          check("busy_cycles", busy_run, 32'd160);
          check("pattern_in_done", {28'd0, pattern}, 32'd0);
        end
        busy_run = 0;
      end else if (busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end else begin
      busy_run = 0;
    end
    prev_done = done;
  end

  // Monitor for the Gray instance: each dwell pops the next expected pattern.
  int         g_cyc = 0;
  logic [3:0] g_cur = 4'd0;
  always @(negedge clk) begin
    if (busy_g) begin
      if (g_cyc % 10 == 0) begin
        if (g_q.size() == 0) check("gray_queue_underflow", 32'd1, 32'd0);
        else g_cur = g_q.pop_front();
      end
      check("gray_pattern", {28'd0, pattern_g}, {28'd0, g_cur});
      g_cyc++;
    end else if (done_g) begin
      check("gray_busy_cycles", g_cyc, 32'd160);
      check("gray_pass", {31'd0, pass_g}, 32'd1);
      check("gray_err_cnt", {27'd0, err_cnt_g}, 32'd0);
      g_cyc = 0;
    end
  end

  task automatic start_sweep();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic push(input logic p, input logic [4:0] e, input logic [3:0] f);
    exp_t x;
    x.pass = p; x.err = e; x.ff = f;
    sb_q.push_back(x);
  endtask

  initial begin
    gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; start_g = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pattern", {28'd0, pattern}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_err_cnt", {27'd0, err_cnt}, 32'd0);
    check("rst_first_fail", {28'd0, first_fail}, 32'd0);
    rst_n = 1'b1;

    // Matching DUT, stuck-at-0 and stuck-at-1 responses.
    mode = 2'd0; push(1'b1, 5'd0, 4'h0);  start_sweep(); wait_done("clean");
    mode = 2'd1; push(1'b0, 5'd1, 4'hF);  start_sweep(); wait_done("tied0");
    mode = 2'd2; push(1'b0, 5'd15, 4'h0); start_sweep(); wait_done("tied1");

    // Start during SWEEP is ignored; results hold afterwards.
    mode = 2'd0; push(1'b1, 5'd0, 4'h0); start_sweep();
    repeat (30) @(negedge clk);
    start_sweep();
    wait_done("start_ignored");
    repeat (5) @(negedge clk);
    check("hold_pass", {31'd0, pass}, 32'd1);
    check("hold_err_cnt", {27'd0, err_cnt}, 32'd0);

    // Abort on SWEEP cycle 50: four dwells sampled, fifth discarded.
    mode = 2'd2; start_sweep();
    repeat (49) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_pattern", {28'd0, pattern}, 32'd0);
    check("abort_pass", {31'd0, pass}, 32'd0);
    check("abort_err_cnt", {27'd0, err_cnt}, 32'd4);
    check("abort_first_fail", {28'd0, first_fail}, 32'd0);
    @(negedge clk) abort = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_restart", {31'd0, busy}, 32'd0);

    // Start together with abort in IDLE is ignored.
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    check("start_abort_idle", {31'd0, busy}, 32'd0);
    mode = 2'd0; push(1'b1, 5'd0, 4'h0); start_sweep(); wait_done("after_abort");

    // Asynchronous reset mid-sweep, between clock edges.
    mode = 2'd2; start_sweep();
    repeat (70) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pattern", {28'd0, pattern}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_pass", {31'd0, pass}, 32'd0);
    check("arst_err_cnt", {27'd0, err_cnt}, 32'd0);
    check("arst_first_fail", {28'd0, first_fail}, 32'd0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_stays_idle", {31'd0, busy}, 32'd0);
    mode = 2'd0; push(1'b1, 5'd0, 4'h0); start_sweep(); wait_done("after_reset");

    // Gray-order sweep on the second instance.
    for (int i = 0; i < 16; i++) g_q.push_back(gray_tab[i]);
    @(negedge clk) start_g = 1'b1;
    @(negedge clk) start_g = 1'b0;
    begin
      int n;
      n = 0;
      while (!done_g && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (!done_g) check("gray_timeout", 32'd0, 32'd1);
    end
    repeat (3) @(negedge clk);

    check("sb_drained", sb_q.size(), 32'd0);
    check("gray_drained", g_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
